// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Central stall/flush sequencer for the 5-stage RV32I pipeline. Detects
// load-use hazards and taken branches, handshakes with the data cache for
// MEM-stage loads/stores and waits out instruction-cache misses. Drives the
// per-stage pipeline-register write enables, the IF/ID flush and ID/EX bubble
// controls, and the one-cycle mem_done strobe for the EX-stage bypass unit.
// Also keeps a saturating stall-cycle counter and a sticky data-memory
// timeout flag.
//
// Ports
//   clk             clock, rising edge
//   reset           asynchronous, active-high reset; forces all outputs to 0
//   ifid_rs1/rs2    source registers of the instruction in ID
//   idex_rd         destination register of the instruction in EX
//   idex_memread    instruction in EX is a load
//   branch_taken    branch/jump in EX resolved taken
//   exmem_memread   MEM-stage instruction is a load
//   exmem_memwrite  MEM-stage instruction is a store
//   dmem_done       data cache completion (load data valid this cycle)
//   imem_ready      instruction cache returns a valid fetch this cycle
//   pc_write .. memwb_write   pipeline-register load enables
//   ifid_flush      load NOP into IF/ID
//   idex_bubble     load NOP into ID/EX
//   dmem_req        data cache request (level)
//   mem_done        load/store completion strobe to the bypass unit
//   state           FSM state, debug only
//   stall_cycles    saturating count of cycles with pc_write = 0
//   err             sticky data-memory timeout flag
//
// State | meaning
// ------+------------------------------------------------------------------
// RUN   | normal issue; branch / load-use / miss / data access detection
// DWAIT | whole pipeline frozen while the data cache completes the access
// IWAIT | fetch stalled on an I-cache miss; IF/ID flushed, rest advances
// ERR   | data cache never answered; pipeline frozen until reset
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic             branch_taken,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic             dmem_done,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             dmem_req,
  output logic             mem_done,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             err
);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_DWAIT = 2'b01;
  localparam logic [1:0] ST_IWAIT = 2'b10;
  localparam logic [1:0] ST_ERR   = 2'b11;

  localparam int                WAIT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  // write enables packed as {pc, ifid, idex, exmem, memwb}
  localparam logic [4:0] WEN_ALL  = 5'b11111;
  localparam logic [4:0] WEN_NONE = 5'b00000;

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [WAIT_W-1:0] wait_inc;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              err_q, err_d;

  logic [4:0] wen_c;
  logic       ifid_flush_c;
  logic       idex_bubble_c;
  logic       dmem_req_c;
  logic       mem_done_c;
  logic       data_access;
  logic       load_use;
  logic       hazard_en;

  always_comb begin
    data_access = exmem_memread | exmem_memwrite;
    load_use    = idex_memread && (idex_rd != 5'd0) &&
                  ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
    wait_inc    = wait_cnt_q + WAIT_W'(1);

    wen_c         = WEN_ALL;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    dmem_req_c    = 1'b0;
    mem_done_c    = 1'b0;
    hazard_en     = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    err_d         = err_q;

    case (state_q)
      ST_RUN: begin
        if (data_access) begin
          wen_c      = WEN_NONE;
          dmem_req_c = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_DWAIT;
        end else if (!imem_ready) begin
          wen_c[4]     = 1'b0;
          ifid_flush_c = 1'b1;
          state_d      = ST_IWAIT;
        end else begin
          hazard_en = 1'b1;
        end
      end

      ST_DWAIT: begin
        dmem_req_c = 1'b1;
        if (dmem_done) begin
          // Pipeline advances this cycle, so EX/ID hazards still need service.
          mem_done_c = 1'b1;
          hazard_en  = 1'b1;
          state_d    = ST_RUN;
        end else begin
          wen_c      = WEN_NONE;
          wait_cnt_d = wait_inc;
          if (wait_inc == WAIT_LAST) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end

      ST_IWAIT: begin
        if (data_access) begin
          wen_c      = WEN_NONE;
          dmem_req_c = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_DWAIT;
        end else if (imem_ready) begin
          hazard_en = 1'b1;
          state_d   = ST_RUN;
        end else begin
          wen_c[4]     = 1'b0;
          ifid_flush_c = 1'b1;
          if (branch_taken) begin
            // Redirect the PC now; the miss wait continues at the new target.
            wen_c[4]      = 1'b1;
            idex_bubble_c = 1'b1;
          end
        end
      end

      default: begin
        wen_c = WEN_NONE;
        err_d = 1'b1;
      end
    endcase

    if (hazard_en) begin
      if (branch_taken) begin
        ifid_flush_c  = 1'b1;
        idex_bubble_c = 1'b1;
      end else if (load_use) begin
        wen_c[4]      = 1'b0;
        wen_c[3]      = 1'b0;
        idex_bubble_c = 1'b1;
      end
    end

    if (!wen_c[4] && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  // Reset gates every output combinationally so a reset mid-access drops
  // dmem_req in the same cycle instead of waiting for a clock edge.
  assign {pc_write, ifid_write, idex_write, exmem_write, memwb_write} =
         reset ? WEN_NONE : wen_c;
  assign ifid_flush   = ifid_flush_c  & ~reset;
  assign idex_bubble  = idex_bubble_c & ~reset;
  assign dmem_req     = dmem_req_c    & ~reset;
  assign mem_done     = mem_done_c    & ~reset;
  assign state        = reset ? ST_RUN : state_q;
  assign stall_cycles = reset ? '0 : stall_cnt_q;
  assign err          = err_q & ~reset;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic mr, br, exr, exw, dd, ir;
  } in_t;

  typedef struct {
    in_t        i;
    logic [8:0] o;   // {pc,ifid,idex,exmem,memwb,flush,bubble,req,mdone}
    logic [1:0] st;
  } vec_t;

  typedef struct {
    int mode;    // 0 run, 1 data wait, 2 fetch wait, 3 error
    int waited;
    int stalls;
    bit err;
  } mstate_t;

  typedef struct {
    logic [8:0] o;
    logic [1:0] st;
    logic       e;
    int         stalls;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] ifid_rs1 = '0, ifid_rs2 = '0, idex_rd = '0;
  logic idex_memread = 0, branch_taken = 0, exmem_memread = 0, exmem_memwrite = 0;
  logic dmem_done = 0, imem_ready = 1;

  logic pc_a, ifid_a, idex_a, exmem_a, memwb_a, flush_a, bubble_a, req_a, mdone_a, err_a;
  logic [1:0]  st_a;
  logic [15:0] stalls_a;
  logic pc_b, ifid_b, idex_b, exmem_b, memwb_b, flush_b, bubble_b, req_b, mdone_b, err_b;
  logic [1:0]  st_b;
  logic [3:0]  stalls_b;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl dut_a (
    .clk(clk), .reset(reset), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .branch_taken(branch_taken), .exmem_memread(exmem_memread),
    .exmem_memwrite(exmem_memwrite), .dmem_done(dmem_done), .imem_ready(imem_ready),
    .pc_write(pc_a), .ifid_write(ifid_a), .idex_write(idex_a), .exmem_write(exmem_a),
    .memwb_write(memwb_a), .ifid_flush(flush_a), .idex_bubble(bubble_a), .dmem_req(req_a),
    .mem_done(mdone_a), .state(st_a), .stall_cycles(stalls_a), .err(err_a));

  pipeline_stall_ctrl #(.CNT_W(4), .TIMEOUT(8)) dut_b (
    .clk(clk), .reset(reset), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .branch_taken(branch_taken), .exmem_memread(exmem_memread),
    .exmem_memwrite(exmem_memwrite), .dmem_done(dmem_done), .imem_ready(imem_ready),
    .pc_write(pc_b), .ifid_write(ifid_b), .idex_write(idex_b), .exmem_write(exmem_b),
    .memwb_write(memwb_b), .ifid_flush(flush_b), .idex_bubble(bubble_b), .dmem_req(req_b),
    .mem_done(mdone_b), .state(st_b), .stall_cycles(stalls_b), .err(err_b));

  function automatic logic [8:0] outs_a();
    return {pc_a, ifid_a, idex_a, exmem_a, memwb_a, flush_a, bubble_a, req_a, mdone_a};
  endfunction

  function automatic logic [8:0] outs_b();
    return {pc_b, ifid_b, idex_b, exmem_b, memwb_b, flush_b, bubble_b, req_b, mdone_b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk_in(input int rs1, input int rs2, input int rd, input bit mr,
                                input bit br, input bit exr, input bit exw, input bit dd,
                                input bit ir);
    in_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.mr = mr; v.br = br; v.exr = exr; v.exw = exw; v.dd = dd; v.ir = ir;
    return v;
  endfunction

  function automatic in_t idle_in();
    return mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  task automatic drive(input in_t v);
    ifid_rs1 = v.rs1; ifid_rs2 = v.rs2; idex_rd = v.rd;
    idex_memread = v.mr; branch_taken = v.br;
    exmem_memread = v.exr; exmem_memwrite = v.exw;
    dmem_done = v.dd; imem_ready = v.ir;
  endtask

  // Apply inputs right after the falling edge; outputs sampled 2 time units
  // later, well before the next rising edge.
  task automatic step(input in_t v);
    @(negedge clk);
    drive(v);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(idle_in());
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference behaviour written straight from the stall/flush rules.
  function automatic void model_step(input mstate_t cur, input logic rst, input in_t i,
                                     input int tmo, input int cmax,
                                     output exp_t e, output mstate_t nx);
    logic pc = 1, ifw = 1, idw = 1, exw = 1, mww = 1;
    logic fl = 0, bb = 0, rq = 0, md = 0;
    bit   run_rules = 0;
    bit   data = i.exr || i.exw;
    bit   lu = i.mr && (i.rd != 0) && ((i.rd == i.rs1) || (i.rd == i.rs2));
    nx = cur;
    if (rst) begin
      e.o = '0; e.st = '0; e.e = 1'b0; e.stalls = 0;
      nx.mode = 0; nx.waited = 0; nx.stalls = 0; nx.err = 0;
      return;
    end
    case (cur.mode)
      0: begin
        if (data) begin
          {pc, ifw, idw, exw, mww} = '0; rq = 1; nx.mode = 1; nx.waited = 0;
        end else if (!i.ir) begin
          pc = 0; fl = 1; nx.mode = 2;
        end else run_rules = 1;
      end
      1: begin
        rq = 1;
        if (i.dd) begin
          md = 1; run_rules = 1; nx.mode = 0;
        end else begin
          {pc, ifw, idw, exw, mww} = '0;
          nx.waited = cur.waited + 1;
          if (nx.waited == tmo) begin nx.mode = 3; nx.err = 1; end
        end
      end
      2: begin
        if (data) begin
          {pc, ifw, idw, exw, mww} = '0; rq = 1; nx.mode = 1; nx.waited = 0;
        end else if (i.ir) begin
          run_rules = 1; nx.mode = 0;
        end else begin
          fl = 1;
          if (i.br) begin pc = 1; bb = 1; end else pc = 0;
        end
      end
      default: begin
        {pc, ifw, idw, exw, mww} = '0; nx.err = 1;
      end
    endcase
    if (run_rules) begin
      if (i.br) begin fl = 1; bb = 1; end
      else if (lu) begin pc = 0; ifw = 0; bb = 1; end
    end
    if (!pc && cur.stalls < cmax) nx.stalls = cur.stalls + 1;
    e.o = {pc, ifw, idw, exw, mww, fl, bb, rq, md};
    e.st = 2'(cur.mode);
    e.e = cur.err;
    e.stalls = cur.stalls;
  endfunction

  vec_t tbl[18];

  initial begin
    int req_cnt, frz_cnt, md_cnt, dw_cnt;
    bit reached;
    mstate_t ma, mb, na, nb;
    exp_t ea, eb;
    in_t v;
    logic rst_now;

    // rs1 rs2 rd mr br exr exw dd ir | outputs | state
    tbl[0]  = '{mk_in(1, 2, 3, 1, 0, 0, 0, 0, 1), 9'b11111_0000, 2'b00};
    tbl[1]  = '{mk_in(1, 5, 5, 1, 0, 0, 0, 0, 1), 9'b00111_0100, 2'b00};
    tbl[2]  = '{mk_in(1, 5, 5, 0, 0, 0, 0, 0, 1), 9'b11111_0000, 2'b00};
    tbl[3]  = '{mk_in(0, 0, 0, 1, 0, 0, 0, 0, 1), 9'b11111_0000, 2'b00};
    tbl[4]  = '{mk_in(1, 2, 3, 0, 1, 1, 0, 0, 1), 9'b00000_0010, 2'b00};
    tbl[5]  = '{mk_in(1, 2, 3, 0, 1, 1, 0, 0, 1), 9'b00000_0010, 2'b01};
    tbl[6]  = '{mk_in(1, 2, 3, 0, 1, 1, 0, 0, 1), 9'b00000_0010, 2'b01};
    tbl[7]  = '{mk_in(1, 2, 3, 0, 1, 1, 0, 1, 1), 9'b11111_1111, 2'b01};
    tbl[8]  = '{mk_in(1, 2, 3, 0, 0, 0, 0, 0, 0), 9'b01111_1000, 2'b00};
    tbl[9]  = '{mk_in(1, 2, 3, 0, 0, 0, 0, 0, 0), 9'b01111_1000, 2'b10};
    tbl[10] = '{mk_in(1, 2, 3, 0, 1, 0, 0, 0, 0), 9'b11111_1100, 2'b10};
    tbl[11] = '{mk_in(1, 2, 3, 0, 0, 0, 0, 0, 0), 9'b01111_1000, 2'b10};
    tbl[12] = '{mk_in(1, 2, 3, 0, 0, 0, 1, 0, 0), 9'b00000_0010, 2'b10};
    tbl[13] = '{mk_in(1, 2, 3, 0, 0, 0, 1, 1, 1), 9'b11111_0011, 2'b01};
    tbl[14] = '{mk_in(1, 2, 3, 0, 0, 0, 0, 1, 1), 9'b11111_0000, 2'b00};
    tbl[15] = '{mk_in(1, 2, 3, 0, 0, 0, 0, 0, 0), 9'b01111_1000, 2'b00};
    tbl[16] = '{mk_in(7, 2, 7, 1, 0, 0, 0, 0, 1), 9'b00111_0100, 2'b10};
    tbl[17] = '{mk_in(7, 2, 7, 0, 0, 0, 0, 0, 1), 9'b11111_0000, 2'b00};

    // Reset: everything forced low, then RUN defaults once released.
    #2;
    chk("reset_outs", 32'(outs_a()), 32'd0);
    chk("reset_state", 32'(st_a), 32'd0);
    do_reset();
    #2;
    chk("post_reset_outs", 32'(outs_a()), 32'(9'b11111_0000));
    chk("post_reset_cnt", 32'(stalls_a), 32'd0);
    chk("post_reset_err", 32'(err_a), 32'd0);

    // Vector table
    for (int k = 0; k < 18; k++) begin
      step(tbl[k].i);
      chk($sformatf("tbl%0d_outs_a", k), 32'(outs_a()), 32'(tbl[k].o));
      chk($sformatf("tbl%0d_state_a", k), 32'(st_a), 32'(tbl[k].st));
      chk($sformatf("tbl%0d_outs_b", k), 32'(outs_b()), 32'(tbl[k].o));
    end

    // Load through a 3-cycle cache
    do_reset();
    req_cnt = 0; frz_cnt = 0; md_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step(mk_in(0, 0, 0, 0, 0, 1, 0, (k == 3), 1));
      if (req_a) req_cnt++;
      if ({pc_a, ifid_a, idex_a, exmem_a, memwb_a} == 5'b00000) frz_cnt++;
      if (mdone_a) md_cnt++;
    end
    step(idle_in());
    if (mdone_a) md_cnt++;
    if (req_a) req_cnt++;
    chk("load3_req_cycles", 32'(req_cnt), 32'd4);
    chk("load3_frozen_cycles", 32'(frz_cnt), 32'd3);
    chk("load3_mem_done_pulses", 32'(md_cnt), 32'd1);
    chk("load3_stall_cycles", 32'(stalls_a), 32'd3);
    chk("load3_state", 32'(st_a), 32'd0);

    // Timeout (dut_b, TIMEOUT=8), then asynchronous reset mid-cycle
    do_reset();
    step(mk_in(0, 0, 0, 0, 0, 1, 0, 0, 1));
    dw_cnt = 0; reached = 0;
    for (int k = 0; k < 20 && !reached; k++) begin
      step(mk_in(0, 0, 0, 0, 0, 1, 0, 0, 1));
      if (st_b == 2'b11) reached = 1;
      else if (st_b == 2'b01) dw_cnt++;
    end
    chk("timeout_reached", 32'(reached), 32'd1);
    chk("timeout_dwait_cycles", 32'(dw_cnt), 32'd8);
    chk("timeout_err", 32'(err_b), 32'd1);
    chk("timeout_outs_b", 32'(outs_b()), 32'd0);
    chk("timeout_a_still_dwait", 32'(st_a), 32'd1);
    chk("timeout_a_req", 32'(req_a), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_state_b", 32'(st_b), 32'd0);
    chk("async_rst_err_b", 32'(err_b), 32'd0);
    chk("async_rst_req_a", 32'(req_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("after_rst_state_b", 32'(st_b), 32'd0);
    chk("after_rst_err_b", 32'(err_b), 32'd0);

    // Stall counter saturation (dut_b, CNT_W=4)
    do_reset();
    for (int k = 0; k < 20; k++) step(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(idle_in());
    chk("sat_stalls_b", 32'(stalls_b), 32'd15);
    chk("sat_stalls_a", 32'(stalls_a), 32'd20);

    // Randomized run against the reference model
    do_reset();
    ma = '{0, 0, 0, 0};
    mb = '{0, 0, 0, 0};
    for (int c = 0; c < 3000; c++) begin
      v.rs1 = 5'($urandom_range(0, 3));
      v.rs2 = 5'($urandom_range(0, 3));
      v.rd  = 5'($urandom_range(0, 3));
      v.mr  = ($urandom_range(0, 99) < 40);
      v.br  = ($urandom_range(0, 99) < 20);
      v.exr = ($urandom_range(0, 99) < 12);
      v.exw = ($urandom_range(0, 99) < 8);
      v.dd  = ($urandom_range(0, 99) < 35);
      v.ir  = ($urandom_range(0, 99) < 80);
      rst_now = ($urandom_range(0, 149) == 0);
      @(negedge clk);
      drive(v);
      reset = rst_now;
      #2;
      model_step(ma, rst_now, v, 255, 65535, ea, na);
      model_step(mb, rst_now, v, 8, 15, eb, nb);
      chk("rand_outs_a", 32'(outs_a()), 32'(ea.o));
      chk("rand_state_a", 32'(st_a), 32'(ea.st));
      chk("rand_stalls_a", 32'(stalls_a), 32'(ea.stalls));
      chk("rand_outs_b", 32'(outs_b()), 32'(eb.o));
      chk("rand_state_b", 32'(st_b), 32'(eb.st));
      chk("rand_stalls_b", 32'(stalls_b), 32'(eb.stalls));
      chk("rand_err_b", 32'(err_b), 32'(eb.e));
      ma = na;
      mb = nb;
    end
    @(negedge clk);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
